seq_mul: RTL and testbench
==========================

# seq_mul

Parametrised sequential shift-add multiplier for the CPU execute stage, the next generation of the team's combinational repeated-addition `mul` unit. It takes a start pulse, iterates one multiplier bit per clock, supports unsigned and two's-complement signed operands, and returns a full 2×WIDTH product split into low and high halves plus an overflow flag. It is driven by the decode/issue logic and holds its result until the next accepted start.

## Interface
- `WIDTH`, 16, operand width in bits; legal range 4–32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only while the block is not busy.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `rs1_reg`  in  WIDTH  multiplicand; sampled with `start`.
- `rs2_reg`  in  WIDTH  multiplier; sampled with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; result valid from this cycle on.
- `mul_rd`  out  WIDTH  low half of the product.
- `m_co`  out  WIDTH  high half of the product.
- `m_ov`  out  1  product does not fit in WIDTH bits.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE/DONE with `start`=1 → RUN.**
  - Latch |rs1| and |rs2|; magnitudes are taken only when `signed_mode`=1.
  - Latch the product sign, rs1[MSB]^rs2[MSB], which is forced to 0 when unsigned.
  - Clear the 2×WIDTH accumulator and the iteration counter.
- **RUN, one iteration per clock:**
  - If multiplier bit0 = 1, add the multiplicand into the accumulator's upper half, keeping a WIDTH+1-bit carry.
  - Shift the accumulator and the multiplier right by 1.
  - Increment the counter.
- **RUN → DONE** when the counter reaches WIDTH−1. An early exit is also possible under the macro (see Configuration).
  - On that edge, register the final product into `mul_rd` and `m_co`, two's-complement negated if the latched sign is 1.
  - On the same edge, compute `m_ov`:
    - Unsigned: `m_ov` = (m_co != 0).
    - Signed: `m_ov` = (m_co != {WIDTH{mul_rd[MSB]}}).
- **DONE → IDLE** after one cycle, unless `start`=1 is accepted; back-to-back operations are allowed.
- `start` in RUN is ignored. No queueing.
- Outputs hold their value from `done` until the edge that completes the next operation.
- Arithmetic:
  - Full product is exact for all inputs.
  - Signed MIN×MIN = +2^(2W−2), with no wrap.
  - A zero operand gives product 0 with `m_ov`=0.
  - A negative×0 result is +0.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `mul_rd`=0, `m_co`=0, `m_ov`=0.
  - State IDLE.
  - All internal registers 0.
- Start edge E0 is the edge that samples `start`.
  - `busy` is high from E0 through the edge that enters DONE.
  - `done` goes high exactly N edges after E0, with N = WIDTH (16 by default); `busy` is low in the `done` cycle.
- `done` is exactly one cycle wide. `done` and `busy` are never high together.
- Asserting `rst` mid-RUN aborts the operation immediately: no `done` pulse, outputs return to 0.
- `start` high for multiple cycles in IDLE/DONE behaves as follows:
  - Each sampled high is a new request.
  - While in RUN it is ignored.

## Configuration
- `SEQ_MUL_EARLY_TERM_EN` defined:
  - RUN also exits when the multiplier shifted right by one is zero.
  - N = index of the highest set bit of |rs2| + 1.
  - For |rs2| = 0, N = 1.
  - Result values are identical to the non-macro build.
- Not defined: N = WIDTH always, giving fixed latency.

## Test plan
- **Unsigned small**
  - Stimulus: `rs1`=3, `rs2`=5, `signed_mode`=0, `start` pulse.
  - Response: `done` 16 edges later; `mul_rd`=0x000F, `m_co`=0, `m_ov`=0.
- **Unsigned max**
  - Stimulus: 0xFFFF × 0xFFFF.
  - Response: `mul_rd`=0x0001, `m_co`=0xFFFE, `m_ov`=1.
- **Signed mixed sign and MIN×MIN**
  - Stimulus: −3 × 5, signed.
  - Response: `mul_rd`=0xFFF1, `m_co`=0xFFFF, `m_ov`=0.
  - Stimulus: 0x8000 × 0x8000, signed.
  - Response: `mul_rd`=0x0000, `m_co`=0x4000, `m_ov`=1.
- **Handshake**
  - `start` pulsed again mid-RUN: ignored, exactly one `done`.
  - `start` held high in the `done` cycle with 2×7: second `done` 16 edges later with `mul_rd`=14.
- **Reset mid-op**
  - Stimulus: `rst` asserted 5 edges after start.
  - Response: all outputs 0, no `done`; a fresh 6×7 then yields 42.
- **Early termination (macro defined)**
  - `rs2`=5: `done` 3 edges after start.
  - `rs2`=0: `done` 1 edge after start, product 0.
  - Signed `rs2`=−1: `done` 1 edge after start.

Source files
------------

// File: rtl/seq_mul_if.sv
// seq_mul_if: request/result bundle between issue logic (master) and the seq_mul multiplier (slave)
interface seq_mul_if #(parameter int WIDTH = 16);
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] rs1_reg;
  logic [WIDTH-1:0] rs2_reg;
  logic busy;
  logic done;
  logic [WIDTH-1:0] mul_rd;
  logic [WIDTH-1:0] m_co;
  logic m_ov;
  modport master(output start, signed_mode, rs1_reg, rs2_reg, input busy, done, mul_rd, m_co, m_ov);
  modport slave(input start, signed_mode, rs1_reg, rs2_reg, output busy, done, mul_rd, m_co, m_ov);
endinterface

// File: rtl/seq_mul.sv
// seq_mul: sequential shift-add multiplier, one multiplier bit per clock, signed/unsigned, 2*WIDTH result.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mul #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  seq_mul_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, mag1, mag2;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod, res;
  logic [WIDTH:0] sum;
  logic [CW-1:0] cnt;
  logic neg, sm, last, accept;
  assign accept = bus.start && state != RUN;
  assign mag1 = (bus.signed_mode && bus.rs1_reg[WIDTH-1]) ? -bus.rs1_reg : bus.rs1_reg;
  assign mag2 = (bus.signed_mode && bus.rs2_reg[WIDTH-1]) ? -bus.rs2_reg : bus.rs2_reg;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_nxt = {sum, acc[WIDTH-1:1]};
`ifdef SEQ_MUL_EARLY_TERM_EN
  assign last = cnt == CW'(WIDTH - 1) || mplier[WIDTH-1:1] == '0;
  // an early exit skips the trailing pure shifts, so apply them in one step
  assign prod = acc_nxt >> (CW'(WIDTH - 1) - cnt);
`else
  assign last = cnt == CW'(WIDTH - 1);
  assign prod = acc_nxt;
`endif
  assign res = neg ? -prod : prod;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? RUN : IDLE;
      RUN: state_nxt = last ? DONE : RUN;
      default: state_nxt = accept ? RUN : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      sm <= 1'b0;
      bus.mul_rd <= '0;
      bus.m_co <= '0;
      bus.m_ov <= 1'b0;
    end else if (accept) begin
      mcand <= mag1;
      mplier <= mag2;
      acc <= '0;
      cnt <= '0;
      neg <= bus.signed_mode && (bus.rs1_reg[WIDTH-1] ^ bus.rs2_reg[WIDTH-1]);
      sm <= bus.signed_mode;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      mplier <= mplier >> 1;
      cnt <= cnt + CW'(1);
      if (last) begin
        bus.mul_rd <= res[WIDTH-1:0];
        bus.m_co <= res[2*WIDTH-1:WIDTH];
        bus.m_ov <= sm ? res[2*WIDTH-1:WIDTH] != {WIDTH{res[WIDTH-1]}} : res[2*WIDTH-1:WIDTH] != '0;
      end
    end
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: randomized + directed scoreboard bench for seq_mul against an arithmetic reference model.
module tb_seq_mul;
  localparam int W = 16;
  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic ov;
    int t0;
    int n;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  seq_mul_if #(.WIDTH(W)) bus();
  seq_mul #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int t0);
    exp_t e;
    longint p, mb;
    p = s ? longint'($signed(a)) * longint'($signed(b)) : longint'({1'b0, a}) * longint'({1'b0, b});
    e.lo = p[W-1:0];
    e.hi = p[2*W-1:W];
    e.ov = s ? (p < -(longint'(1) << (W - 1)) || p >= (longint'(1) << (W - 1))) : p >= (longint'(1) << W);
    e.t0 = t0;
`ifdef SEQ_MUL_EARLY_TERM_EN
    mb = (s && b[W-1]) ? -longint'($signed(b)) : longint'({1'b0, b});
    e.n = 1;
    for (int i = 0; i < W; i++) if (mb[i]) e.n = i + 1;
`else
    mb = 0;
    e.n = W + int'(mb);
`endif
    return e;
  endfunction
  always @(negedge clk) if (!rst) begin
    chk("done_busy_exclusive", {63'b0, bus.done && bus.busy}, 64'd0);
    if (bus.done) begin
      chk("done_expected", {63'b0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("mul_rd", 64'(bus.mul_rd), 64'(e.lo));
        chk("m_co", 64'(bus.m_co), 64'(e.hi));
        chk("m_ov", {63'b0, bus.m_ov}, {63'b0, e.ov});
        chk("latency", 64'(cyc - e.t0), 64'(e.n));
      end
    end
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_mode = s;
    bus.rs1_reg = a;
    bus.rs2_reg = b;
    q.push_back(model(a, b, s, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", {63'b0, bus.busy}, 64'd1);
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {63'b0, bus.busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, bus.done}, 64'd0);
    chk({tag, "_mul_rd"}, 64'(bus.mul_rd), 64'd0);
    chk({tag, "_m_co"}, 64'(bus.m_co), 64'd0);
    chk({tag, "_m_ov"}, {63'b0, bus.m_ov}, 64'd0);
  endtask
  initial begin
    logic [W-1:0] da[10] = '{16'd3, 16'hFFFF, 16'hFFFD, 16'h8000, 16'd0, 16'hFFFD, 16'd9, 16'd1234, 16'd77, 16'h7FFF};
    logic [W-1:0] db[10] = '{16'd5, 16'hFFFF, 16'd5, 16'h8000, 16'h1234, 16'd0, 16'd5, 16'd0, 16'hFFFF, 16'h8000};
    logic ds[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.rs1_reg = '0;
    bus.rs2_reg = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    for (int i = 0; i < 10; i++) begin
      issue(da[i], db[i], ds[i]);
      drain();
    end
    // start pulsed mid-operation must be ignored
    issue(16'd11, 16'd13, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.rs1_reg = 16'd500;
    bus.rs2_reg = 16'd600;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    // start held in the done cycle launches a second operation
    issue(16'd3, 16'd4, 1'b0);
    for (int k = 0; k < 40 && !bus.done; k++) @(negedge clk);
    bus.start = 1'b1;
    bus.rs1_reg = 16'd2;
    bus.rs2_reg = 16'd7;
    bus.signed_mode = 1'b0;
    q.push_back(model(16'd2, 16'd7, 1'b0, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    // reset mid-run aborts with no done
    issue(16'h1234, 16'h0F0F, 1'b0);
    drain();
    @(negedge clk);
    bus.start = 1'b1;
    bus.rs1_reg = 16'd100;
    bus.rs2_reg = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_zero("after_abort");
    issue(16'd6, 16'd7, 1'b0);
    drain();
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 5) == 0) a = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
      if ($urandom_range(0, 5) == 0) b = W'($urandom_range(0, 7));
      issue(a, b, 1'(($urandom)));
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
